// File: rtl/seq_alu_datapath.sv
// Sequential ALU datapath: A/B operand registers, answer register with
// feedback, opcode ALU with status flags and a shift-add multiplier.
module seq_alu_datapath #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic             A_select,
    input  logic             B_select,
    input  logic             Aload,
    input  logic             Bload,
    input  logic [2:0]       select_mode,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Output,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MUL  = 2'b10
    } state_t;

    state_t           state_q;
    op_t              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] ans_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             zero_q;
    logic             carry_q;
    logic             ovf_q;

    logic [WIDTH-1:0] a_mux;
    logic [WIDTH-1:0] b_mux;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic [PW-1:0]    acc_nxt;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] mul_hi;
    logic             start_mul;

    assign a_mux = A_select ? ans_q : InputA;
    assign b_mux = B_select ? ans_q : InputB;

    assign start_mul = (select_mode == OP_MUL) && MUL_EN;

    assign Output   = ans_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Zero     = zero_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;

    // Single-cycle ALU evaluated on the operand latches captured at Start.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum_w   = {1'b0, opa_q} + {1'b0, opb_q};
        dif_w   = {1'b0, opa_q} - {1'b0, opb_q};
        unique case (op_q)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != opa_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif_w[WIDTH-1:0];
                alu_c   = dif_w[WIDTH];
                alu_v   = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) &&
                          (dif_w[WIDTH-1] != opa_q[WIDTH-1]);
            end
            OP_AND: alu_res = opa_q & opb_q;
            OP_OR:  alu_res = opa_q | opb_q;
            OP_XOR: alu_res = opa_q ^ opb_q;
            OP_SHL: begin
                alu_res = {opa_q[WIDTH-2:0], 1'b0};
                alu_c   = opa_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, opa_q[WIDTH-1:1]};
                alu_c   = opa_q[0];
            end
            OP_MUL: alu_res = '0;
        endcase
    end

    // One shift-add multiply step: add the shifted multiplicand when the
    // current multiplier LSB is set.
    always_comb begin
        acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mul_lo  = acc_nxt[WIDTH-1:0];
        mul_hi  = acc_nxt[PW-1:WIDTH];
    end

    // Control FSM with operand, multiplier, answer and flag registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            ans_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (Aload) a_q <= a_mux;
                    if (Bload) b_q <= b_mux;
                    if (Start) begin
                        op_q     <= op_t'(select_mode);
                        opa_q    <= a_q;
                        opb_q    <= b_q;
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, a_q};
                        mplier_q <= b_q;
                        busy_q   <= 1'b1;
                        if (start_mul) begin
                            state_q <= S_MUL;
                            cnt_q   <= CW'(WIDTH);
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    ans_q   <= alu_res;
                    zero_q  <= (alu_res == '0);
                    carry_q <= alu_c;
                    ovf_q   <= alu_v;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_MUL: begin
                    acc_q    <= acc_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        ans_q   <= mul_lo;
                        zero_q  <= (mul_lo == '0);
                        carry_q <= (mul_hi != '0);
                        ovf_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_datapath.sv
// Directed self-checking bench for seq_alu_datapath (WIDTH=8, MUL_EN=1).
module tb_seq_alu_datapath;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] InputA;
    logic [7:0] InputB;
    logic       A_select;
    logic       B_select;
    logic       Aload;
    logic       Bload;
    logic [2:0] select_mode;
    logic       Start;
    logic       Busy;
    logic       Done;
    logic [7:0] Output;
    logic       Zero;
    logic       Carry;
    logic       Overflow;

    int n_cmp = 0;
    int n_err = 0;
    int done_n;

    seq_alu_datapath #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .Clk(Clk), .Reset(Reset),
        .InputA(InputA), .InputB(InputB),
        .A_select(A_select), .B_select(B_select),
        .Aload(Aload), .Bload(Bload),
        .select_mode(select_mode), .Start(Start),
        .Busy(Busy), .Done(Done), .Output(Output),
        .Zero(Zero), .Carry(Carry), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        InputA = a; InputB = b;
        A_select = 1'b0; B_select = 1'b0;
        Aload = 1'b1; Bload = 1'b1;
        step();
        Aload = 1'b0; Bload = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic [7:0] o,
                               input logic z, input logic c,
                               input logic v);
        check({tag, " out"}, Output, o);
        check({tag, " zero"}, Zero, z);
        check({tag, " carry"}, Carry, c);
        check({tag, " ovf"}, Overflow, v);
    endtask

    // Start an op and return in the cycle Done is high.
    task automatic do_op(input logic [2:0] op, input int exp_busy,
                         input string tag);
        int  busy_n;
        bit  seen;
        bit  overlap;
        busy_n = 0; seen = 0; overlap = 0;
        select_mode = op;
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done && Busy) overlap = 1;
            if (Done) begin
                seen = 1;
                break;
            end
            if (Busy) busy_n++;
            step();
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " busy cycles"}, busy_n, exp_busy);
        check({tag, " done/busy excl"}, 32'(overlap), 32'd0);
    endtask

    initial begin
        Reset = 1'b1;
        InputA = '0; InputB = '0;
        A_select = 1'b0; B_select = 1'b0;
        Aload = 1'b0; Bload = 1'b0;
        select_mode = 3'b000; Start = 1'b0;
        #2;
        check_flags("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset busy", Busy, 1'b0);
        check("reset done", Done, 1'b0);
        step();
        Reset = 1'b0;
        step();

        load_ab(8'h7F, 8'h01);
        do_op(3'b000, 1, "add7f");
        check_flags("add7f", 8'h80, 1'b0, 1'b0, 1'b1);
        step();
        check("done pulse width", Done, 1'b0);
        check("hold out", Output, 8'h80);

        load_ab(8'h05, 8'h07);
        do_op(3'b001, 1, "sub57");
        check_flags("sub57", 8'hFE, 1'b0, 1'b1, 1'b0);

        load_ab(8'h07, 8'h07);
        do_op(3'b001, 1, "sub77");
        check_flags("sub77", 8'h00, 1'b1, 1'b0, 1'b0);

        load_ab(8'd13, 8'd11);
        do_op(3'b111, 8, "mul13x11");
        check_flags("mul13x11", 8'h8F, 1'b0, 1'b0, 1'b0);

        load_ab(8'd20, 8'd20);
        do_op(3'b111, 8, "mul20x20");
        check_flags("mul20x20", 8'h90, 1'b0, 1'b1, 1'b0);

        load_ab(8'h5A, 8'h0F);
        do_op(3'b010, 1, "and");
        check("and out", Output, 8'h0A);
        do_op(3'b011, 1, "or");
        check("or out", Output, 8'h5F);
        do_op(3'b100, 1, "xor");
        check("xor out", Output, 8'h55);

        load_ab(8'h81, 8'h00);
        do_op(3'b110, 1, "shr");
        check_flags("shr", 8'h40, 1'b0, 1'b1, 1'b0);
        do_op(3'b101, 1, "shl");
        check_flags("shl81", 8'h02, 1'b0, 1'b1, 1'b0);

        load_ab(8'd3, 8'd4);
        do_op(3'b000, 1, "add34");
        check("add34 out", Output, 8'h07);
        A_select = 1'b1; Aload = 1'b1;
        InputB = 8'h01; B_select = 1'b0; Bload = 1'b1;
        step();
        Aload = 1'b0; Bload = 1'b0; A_select = 1'b0;
        do_op(3'b101, 1, "fb shl");
        check_flags("fb shl", 8'h0E, 1'b0, 1'b0, 1'b0);
        B_select = 1'b1; Bload = 1'b1;
        step();
        Bload = 1'b0; B_select = 1'b0;
        do_op(3'b001, 1, "fb sub");
        check_flags("fb sub", 8'hF9, 1'b0, 1'b1, 1'b0);

        load_ab(8'd3, 8'd5);
        select_mode = 3'b111; Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        select_mode = 3'b000; Start = 1'b1;
        step();
        Start = 1'b0;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done) done_n++;
            step();
        end
        check("start while busy dones", done_n, 1);
        check("start while busy out", Output, 8'h0F);

        load_ab(8'h02, 8'h03);
        InputA = 8'h10; A_select = 1'b0; Aload = 1'b1;
        do_op(3'b000, 1, "start+aload");
        Aload = 1'b0;
        check("start+aload out", Output, 8'h05);
        do_op(3'b000, 1, "new a");
        check("new a out", Output, 8'h13);

        load_ab(8'h02, 8'h03);
        select_mode = 3'b111; Start = 1'b1;
        step();
        Start = 1'b0;
        InputA = 8'h55; Aload = 1'b1;
        step();
        step();
        Aload = 1'b0;
        for (int i = 0; i < 20 && !Done; i++) step();
        check("busy aload done", Done, 1'b1);
        check("busy aload mul", Output, 8'h06);
        do_op(3'b000, 1, "a kept");
        check("a kept out", Output, 8'h05);

        load_ab(8'd20, 8'd20);
        do_op(3'b111, 8, "pre reset");
        step();
        load_ab(8'd13, 8'd11);
        select_mode = 3'b111; Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        check("mid mul busy", Busy, 1'b1);
        Reset = 1'b1;
        #1;
        check_flags("mid reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("mid reset busy", Busy, 1'b0);
        check("mid reset done", Done, 1'b0);
        step();
        Reset = 1'b0;
        step();
        load_ab(8'd13, 8'd11);
        do_op(3'b111, 8, "post reset mul");
        check_flags("post reset mul", 8'h8F, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_alu_datapath.md
Name: seq_alu_datapath

Overview:
- Parametrised successor to the two-operand A/B/ALU/answer-register datapath.
- Operand registers A and B load from external inputs or from the answer register, as before.
- New: 3-bit opcode ALU with status flags; Start/Busy/Done handshake; multi-cycle shift-add multiplier.
- Sits between the control unit and the answer-feedback path of the CPU.

Parameters:
- WIDTH, 8, datapath width of operands, answer register and Output.
- MUL_EN, 1, 1 = opcode 111 is the multi-cycle multiply; 0 = opcode 111 completes single-cycle with result 0.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears all registers and returns the FSM to IDLE.
- InputA  input  WIDTH  external operand for A.
- InputB  input  WIDTH  external operand for B.
- A_select  input  1  A source: 0 = InputA, 1 = answer register.
- B_select  input  1  B source: 0 = InputB, 1 = answer register.
- Aload  input  1  load A from its mux on the clock edge.
- Bload  input  1  load B from its mux on the clock edge.
- select_mode  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL by 1, 110 SHR by 1 (logical), 111 MUL.
- Start  input  1  begin operation; sampled only in IDLE.
- Busy  output  1  high from the edge after Start is accepted until the result is written.
- Done  output  1  one-cycle pulse, aligned with the cycle the new result is visible.
- Output  output  WIDTH  answer register.
- Zero  output  1  registered flag: result == 0.
- Carry  output  1  registered carry/borrow/shift-out flag.
- Overflow  output  1  registered signed-overflow flag.

Behaviour:
- Reset: A, B, answer register, Output, flags, Busy, Done, counter all 0; FSM goes to IDLE. Reset is immediate, including mid-operation.
- A/B loads: take effect on any edge while Busy=0. Aload/Bload are ignored while Busy=1.
- Start accepted (IDLE, Start=1 at edge k):
  - opcode and current A/B register values (pre-load) are captured into operand latches;
  - a simultaneous Aload/Bload still updates A/B but does not affect this operation;
  - Busy=1 after edge k.
- FSM states:
  - IDLE -> EXEC on Start, if opcode != 111 or MUL_EN = 0.
  - IDLE -> MUL on Start, if opcode = 111 and MUL_EN = 1; counter loaded with WIDTH.
  - EXEC -> IDLE at edge k+1: answer register and flags written, Done=1 and Busy=0 for the following cycle.
  - MUL: one shift-add step per edge; counter decrements. On the edge where the counter reaches 0 (edge k+WIDTH), the result and flags are written, Done=1 for one cycle, FSM -> IDLE, Busy=0.
- Latency: single-cycle ops 1 edge after Start; MUL WIDTH edges after Start.
- Back-to-back: Start may be reasserted in the cycle Done is high and is accepted on that edge.
- Start while Busy: ignored, not queued.
- Multiply: unsigned; internal 2*WIDTH-bit product. The answer register takes the low WIDTH bits.
- Arithmetic: results truncate to WIDTH (wrap-around).
- Carry per opcode:
  - ADD: carry-out.
  - SUB: borrow (A < B unsigned); result is A - B mod 2^WIDTH.
  - SHL: shifted-out MSB of A.
  - SHR: shifted-out LSB of A.
  - MUL: 1 iff the high half of the product is nonzero.
  - Logic ops: 0.
- Overflow: signed overflow for ADD/SUB; 0 for all other opcodes.
- Flags and Output change only on a Done edge or reset; otherwise they hold.
- Done is never high while Busy is high.

Test Plan:
- Reset asserted mid-MUL (Busy=1) -> same cycle Output=0, Zero=0, Carry=0, Overflow=0, Busy=0, Done=0; next Start runs normally.
- A=0x7F, B=0x01, ADD, Start -> Done one edge later, Output=0x80, Carry=0, Overflow=1, Zero=0.
- A=0x05, B=0x07, SUB -> Output=0xFE, Carry=1, Overflow=0; then A=0x07, B=0x07, SUB -> Output=0x00, Zero=1.
- A=13, B=11, MUL -> Busy for exactly 8 cycles, Done on the 8th edge, Output=0x8F, Carry=0. A=20, B=20, MUL -> Output=0x90, Carry=1.
- Feedback: ADD 3+4 -> Output=7; then A_select=1, Aload=1, B=0x01, SHL -> A=7, Output=0x0E, Carry=0. Start pulsed again while Busy during a MUL -> ignored, exactly one Done.
- Start with simultaneous Aload (InputA=0x10, old A=0x02, B=0x03, ADD) -> Output=0x05, A reads 0x10 afterwards. Aload during Busy -> A unchanged.
